// File: rtl/alu_reg_pkg.sv
// alu_reg_pkg: opcodes, sequencer states and opcode-legal check.
// Build option: ALU_MUL_EN makes opcode 8 (MUL) legal.
package alu_reg_pkg;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_SHL  = 4'd5;
  localparam logic [3:0] OP_SHR  = 4'd6;
  localparam logic [3:0] OP_PASS = 4'd7;
  localparam logic [3:0] OP_MUL  = 4'd8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH_A,
    S_FETCH_B,
    S_EXEC,
    S_WRITE,
    S_DONE
  } state_t;

  function automatic logic op_legal(
    input logic [3:0] op
  );
`ifdef ALU_MUL_EN
    return op <= OP_MUL;
`else
    return op <= OP_PASS;
`endif
  endfunction

endpackage

// File: rtl/alu_reg_alu.sv
// alu_reg_alu: combinational ALU. Ports: a, b, opcode in;
// y (result), c (carry/borrow/shift-out), legal out. Uses ALU_MUL_EN.
module alu_reg_alu
  import alu_reg_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [3:0]        opcode,
  output logic [DATA_W-1:0] y,
  output logic              c,
  output logic              legal
);

  logic [2:0]      sh;
  logic [DATA_W:0] sum;
  logic [DATA_W:0] dif;
  logic [DATA_W:0] shl_x;
  logic [DATA_W:0] shr_x;

  assign sh  = b[2:0];
  assign sum = {1'b0, a} + {1'b0, b};
  assign dif = {1'b0, a} - {1'b0, b};

  // One guard bit catches the last bit shifted out;
  // a shift of 0 leaves the guard bit clear.
  assign shl_x = {1'b0, a} << sh;
  assign shr_x = {a, 1'b0} >> sh;

`ifdef ALU_MUL_EN
  logic [2*DATA_W-1:0] prod;
  assign prod = {{DATA_W{1'b0}}, a}
              * {{DATA_W{1'b0}}, b};
`endif

  assign legal = op_legal(opcode);

  always_comb begin
    y = '0;
    c = 1'b0;
    case (opcode)
      OP_ADD: begin
        y = sum[DATA_W-1:0];
        c = sum[DATA_W];
      end
      OP_SUB: begin
        y = dif[DATA_W-1:0];
        c = dif[DATA_W];
      end
      OP_AND: y = a & b;
      OP_OR:  y = a | b;
      OP_XOR: y = a ^ b;
      OP_SHL: begin
        y = shl_x[DATA_W-1:0];
        c = shl_x[DATA_W];
      end
      OP_SHR: begin
        y = shr_x[DATA_W:1];
        c = shr_x[0];
      end
      OP_PASS: y = a;
`ifdef ALU_MUL_EN
      OP_MUL: begin
        y = prod[DATA_W-1:0];
        c = |prod[2*DATA_W-1:DATA_W];
      end
`endif
      default: begin
        y = '0;
        c = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/alu_reg_seq.sv
// alu_reg_seq: reg-reg ALU sequencer with regfile, pc and phase strobes.
// Ports: start/opcode/rs1/rs2/rd launch, host_* regfile access,
// busy/rd_a_en/rd_b_en/alu_en/wb_en/pc_inc/done strobes,
// result/flag_z/flag_c/illegal/pc status. Build option: ALU_MUL_EN.
module alu_reg_seq
  import alu_reg_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int NUM_REGS = 8,
  parameter int PC_W     = 8,
  parameter int SETTLE   = 2,
  localparam int REG_AW  = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [3:0]        opcode,
  input  logic [REG_AW-1:0] rs1,
  input  logic [REG_AW-1:0] rs2,
  input  logic [REG_AW-1:0] rd,
  input  logic              host_we,
  input  logic [REG_AW-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic [DATA_W-1:0] host_rdata,
  output logic              busy,
  output logic              rd_a_en,
  output logic              rd_b_en,
  output logic              alu_en,
  output logic              wb_en,
  output logic              pc_inc,
  output logic              done,
  output logic [DATA_W-1:0] result,
  output logic              flag_z,
  output logic              flag_c,
  output logic              illegal,
  output logic [PC_W-1:0]   pc
);

  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(SETTLE - 1);

  state_t            state;
  logic [CW-1:0]     cnt;
  logic [3:0]        op_q;
  logic [REG_AW-1:0] rs1_q;
  logic [REG_AW-1:0] rs2_q;
  logic [REG_AW-1:0] rd_q;
  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] op_b;
  logic [DATA_W-1:0] rf [NUM_REGS];

  logic [DATA_W-1:0] rd_a_val;
  logic [DATA_W-1:0] rd_b_val;
  logic [DATA_W-1:0] alu_y;
  logic              alu_c;
  logic              alu_legal;
  logic              host_wr;
  logic              wb_wr;

  // Register 0 is hardwired to zero on every read port.
  assign rd_a_val = (rs1_q == '0) ? '0 : rf[rs1_q];
  assign rd_b_val = (rs2_q == '0) ? '0 : rf[rs2_q];
  assign host_rdata =
    (host_addr == '0) ? '0 : rf[host_addr];

  alu_reg_alu #(
    .DATA_W(DATA_W)
  ) u_alu (
    .a      (op_a),
    .b      (op_b),
    .opcode (op_q),
    .y      (alu_y),
    .c      (alu_c),
    .legal  (alu_legal)
  );

  assign busy    = (state != S_IDLE);
  assign rd_a_en = (state == S_FETCH_A);
  assign rd_b_en = (state == S_FETCH_B);
  assign alu_en  = (state == S_EXEC);
  assign wb_en   = (state == S_WRITE);
  assign pc_inc  = (state == S_WRITE);
  assign done    = (state == S_DONE);

  assign host_wr = (state == S_IDLE) && host_we
                && (host_addr != '0);
  assign wb_wr   = (state == S_WRITE) && !illegal
                && (rd_q != '0);

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < NUM_REGS; i++)
        rf[i] <= '0;
    end else if (host_wr) begin
      rf[host_addr] <= host_wdata;
    end else if (wb_wr) begin
      rf[rd_q] <= result;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= S_IDLE;
      cnt     <= '0;
      op_q    <= '0;
      rs1_q   <= '0;
      rs2_q   <= '0;
      rd_q    <= '0;
      op_a    <= '0;
      op_b    <= '0;
      result  <= '0;
      flag_z  <= 1'b0;
      flag_c  <= 1'b0;
      illegal <= 1'b0;
      pc      <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            op_q    <= opcode;
            rs1_q   <= rs1;
            rs2_q   <= rs2;
            rd_q    <= rd;
            illegal <= 1'b0;
            cnt     <= '0;
            state   <= S_FETCH_A;
          end
        end
        S_FETCH_A: begin
          if (cnt == CNT_LAST) begin
            op_a  <= rd_a_val;
            cnt   <= '0;
            state <= S_FETCH_B;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_FETCH_B: begin
          if (cnt == CNT_LAST) begin
            op_b  <= rd_b_val;
            cnt   <= '0;
            state <= S_EXEC;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_EXEC: begin
          result  <= alu_y;
          flag_z  <= (alu_y == '0);
          flag_c  <= alu_c;
          illegal <= !alu_legal;
          state   <= S_WRITE;
        end
        S_WRITE: begin
          pc    <= pc + PC_W'(1);
          state <= S_DONE;
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_reg_seq.sv
// tb_alu_reg_seq: randomized bench for alu_reg_seq against a
// behavioural model of the regfile, pc and ALU.
module tb_alu_reg_seq;

  localparam int DATA_W   = 8;
  localparam int NUM_REGS = 8;
  localparam int PC_W     = 8;
  localparam int SETTLE   = 2;
  localparam int REG_AW   = 3;
  localparam int M        = 1 << DATA_W;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              start = 1'b0;
  logic [3:0]        opcode = '0;
  logic [REG_AW-1:0] rs1 = '0;
  logic [REG_AW-1:0] rs2 = '0;
  logic [REG_AW-1:0] rd = '0;
  logic              host_we = 1'b0;
  logic [REG_AW-1:0] host_addr = '0;
  logic [DATA_W-1:0] host_wdata = '0;
  logic [DATA_W-1:0] host_rdata;
  logic              busy, rd_a_en, rd_b_en;
  logic              alu_en, wb_en, pc_inc, done;
  logic [DATA_W-1:0] result;
  logic              flag_z, flag_c, illegal;
  logic [PC_W-1:0]   pc;

  int checks = 0;
  int errors = 0;
  int mrf [NUM_REGS];
  int mpc = 0;

  alu_reg_seq #(
    .DATA_W   (DATA_W),
    .NUM_REGS (NUM_REGS),
    .PC_W     (PC_W),
    .SETTLE   (SETTLE)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .opcode     (opcode),
    .rs1        (rs1),
    .rs2        (rs2),
    .rd         (rd),
    .host_we    (host_we),
    .host_addr  (host_addr),
    .host_wdata (host_wdata),
    .host_rdata (host_rdata),
    .busy       (busy),
    .rd_a_en    (rd_a_en),
    .rd_b_en    (rd_b_en),
    .alu_en     (alu_en),
    .wb_en      (wb_en),
    .pc_inc     (pc_inc),
    .done       (done),
    .result     (result),
    .flag_z     (flag_z),
    .flag_c     (flag_c),
    .illegal    (illegal),
    .pc         (pc)
  );

  always #10 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  function automatic void model(
    input  int op,
    input  int a,
    input  int b,
    output int y,
    output int c,
    output int il
  );
    int s;
    s  = b % 8;
    y  = 0;
    c  = 0;
    il = 0;
    case (op)
      0: begin
        y = (a + b) % M;
        c = int'(a + b >= M);
      end
      1: begin
        y = (a - b + M) % M;
        c = int'(a < b);
      end
      2: y = a & b;
      3: y = a | b;
      4: y = a ^ b;
      5: begin
        y = (a << s) % M;
        c = (s == 0) ? 0 : (a >> (DATA_W - s)) & 1;
      end
      6: begin
        y = a >> s;
        c = (s == 0) ? 0 : (a >> (s - 1)) & 1;
      end
      7: y = a;
`ifdef ALU_MUL_EN
      8: begin
        y = (a * b) % M;
        c = int'(((a * b) >> DATA_W) != 0);
      end
`endif
      default: il = 1;
    endcase
  endfunction

  task automatic host_wr(input int a, input int d);
    @(negedge clk);
    host_we    = 1'b1;
    host_addr  = a[REG_AW-1:0];
    host_wdata = d[DATA_W-1:0];
    @(negedge clk);
    host_we = 1'b0;
    if (a != 0) mrf[a] = d;
  endtask

  task automatic chk_regs();
    for (int i = 0; i < NUM_REGS; i++) begin
      host_addr = REG_AW'(i);
      #1;
      chk($sformatf("reg%0d", i),
          32'(host_rdata), 32'(mrf[i]));
    end
  endtask

  task automatic run_op(
    input int op, input int a1,
    input int a2, input int d,
    input bit inject
  );
    int ey, ec, eil, cyc, nb;
    int fa, fb, fx, fw, fp, fd;
    model(op, mrf[a1], mrf[a2], ey, ec, eil);
    @(negedge clk);
    opcode = op[3:0];
    rs1    = a1[REG_AW-1:0];
    rs2    = a2[REG_AW-1:0];
    rd     = d[REG_AW-1:0];
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    fa = -1; fb = -1; fx = -1;
    fw = -1; fp = -1; fd = -1;
    while (cyc < 40) begin
      if (rd_a_en && fa < 0) fa = cyc;
      if (rd_b_en && fb < 0) fb = cyc;
      if (alu_en && fx < 0) fx = cyc;
      if (wb_en && fw < 0) fw = cyc;
      if (pc_inc && fp < 0) fp = cyc;
      if (done) begin
        fd = cyc;
        break;
      end
      if (inject) begin
        if (cyc == SETTLE + 1) begin
          start  = 1'b1;
          opcode = 4'd7;
          rs1    = 3'd2;
          rd     = 3'd1;
        end else begin
          start = 1'b0;
        end
        if (cyc == 2 * SETTLE + 1) begin
          host_we    = 1'b1;
          host_addr  = 3'd1;
          host_wdata = 8'hAA;
        end else begin
          host_we = 1'b0;
        end
      end
      @(negedge clk);
      cyc++;
    end
    start   = 1'b0;
    host_we = 1'b0;
    chk("lat_fetch_a", fa, 1);
    chk("lat_fetch_b", fb, SETTLE + 1);
    chk("lat_exec", fx, 2 * SETTLE + 1);
    chk("lat_wb", fw, 2 * SETTLE + 2);
    chk("lat_pc_inc", fp, 2 * SETTLE + 2);
    chk("lat_done", fd, 2 * SETTLE + 3);
    if (eil == 0 && d != 0) mrf[d] = ey;
    mpc = (mpc + 1) % (1 << PC_W);
    chk("result", 32'(result), ey);
    chk("flag_z", 32'(flag_z), 32'(ey == 0));
    chk("flag_c", 32'(flag_c), ec);
    chk("illegal", 32'(illegal), eil);
    chk("pc", 32'(pc), mpc);
    @(negedge clk);
    chk("idle_busy", 32'(busy), 0);
    chk("idle_done", 32'(done), 0);
    if (inject) begin
      nb = 0;
      for (int i = 0; i < 2 * SETTLE + 4; i++) begin
        @(negedge clk);
        if (busy || done) nb++;
      end
      chk("no_relaunch", nb, 0);
    end
  endtask

  task automatic reset_in_exec();
    int cyc;
    @(negedge clk);
    opcode = 4'd0;
    rs1    = 3'd1;
    rs2    = 3'd2;
    rd     = 3'd3;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (!alu_en && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    chk("rst_reach_exec", 32'(alu_en), 1);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_wb", 32'(wb_en), 0);
    chk("rst_pc_inc", 32'(pc_inc), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_result", 32'(result), 0);
    chk("rst_z", 32'(flag_z), 0);
    chk("rst_c", 32'(flag_c), 0);
    chk("rst_illegal", 32'(illegal), 0);
    chk("rst_pc", 32'(pc), 0);
    reset = 1'b1;
    for (int i = 0; i < NUM_REGS; i++) mrf[i] = 0;
    mpc = 0;
    @(negedge clk);
    chk_regs();
  endtask

  initial begin
    int op, a1, a2, d;
    for (int i = 0; i < NUM_REGS; i++) mrf[i] = 0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("init_busy", 32'(busy), 0);
    chk("init_done", 32'(done), 0);
    chk("init_result", 32'(result), 0);
    chk("init_pc", 32'(pc), 0);
    chk("init_illegal", 32'(illegal), 0);
    chk_regs();

    host_wr(1, 'h05);
    host_wr(2, 'h03);
    run_op(0, 1, 2, 3, 1'b0);
    chk("plan_add", 32'(result), 'h08);
    chk("plan_add_pc", 32'(pc), 1);
    chk_regs();

    run_op(1, 2, 1, 4, 1'b0);
    chk("plan_sub", 32'(result), 'hFE);
    chk("plan_sub_c", 32'(flag_c), 1);
    run_op(1, 1, 1, 5, 1'b0);
    chk("plan_sub_z", 32'(flag_z), 1);

    run_op(0, 1, 2, 0, 1'b0);
    run_op(12, 1, 2, 6, 1'b0);
    chk("plan_illegal", 32'(illegal), 1);
    chk_regs();
    run_op(7, 1, 1, 6, 1'b0);
    chk("plan_clr_illegal", 32'(illegal), 0);

    run_op(0, 1, 2, 7, 1'b1);
    chk_regs();

    host_wr(0, 'h55);
    host_wr(1, 'h10);
    host_wr(2, 'h11);
    run_op(8, 1, 2, 3, 1'b0);
`ifdef ALU_MUL_EN
    chk("plan_mul", 32'(result), 'h10);
    chk("plan_mul_c", 32'(flag_c), 1);
`else
    chk("plan_op8_illegal", 32'(illegal), 1);
`endif
    chk_regs();

    for (int n = 0; n < 270; n++) begin
      if ($urandom_range(0, 3) == 0)
        host_wr($urandom_range(0, NUM_REGS - 1),
                $urandom_range(0, M - 1));
      op = $urandom_range(0, 15);
      a1 = $urandom_range(0, NUM_REGS - 1);
      a2 = $urandom_range(0, NUM_REGS - 1);
      d  = $urandom_range(0, NUM_REGS - 1);
      run_op(op, a1, a2, d, 1'b0);
      if (mpc == 0) chk("pc_wrap", 32'(pc), 0);
      if (n % 16 == 0) chk_regs();
    end
    chk_regs();

    reset_in_exec();

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_reg_seq.md
Name: alu_reg_seq

Overview:
Parametrised register-register ALU sequencer with its own register file, ALU, operand latches and program counter. On a start pulse it latches an instruction (opcode, rs1, rs2, rd) and runs operand-A fetch, operand-B fetch, execute, writeback and done phases. Phase lengths are configurable. It sits between the instruction decoder and the datapath and exposes per-phase control strobes for the rest of the design.

Parameters:
DATA_W, 8, register and ALU data width (>=4)
NUM_REGS, 8, register count, power of two >=2; REG_AW = log2(NUM_REGS)
PC_W, 8, program counter width
SETTLE, 2, cycles each operand-fetch phase is held (>=1)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-low reset
start  in  1  launch request, sampled only in IDLE
opcode  in  4  ALU operation, latched at launch
rs1  in  REG_AW  operand-A source register, latched at launch
rs2  in  REG_AW  operand-B source register, latched at launch
rd  in  REG_AW  destination register, latched at launch
host_we  in  1  host register write strobe, honoured only in IDLE
host_addr  in  REG_AW  host write / debug read address
host_wdata  in  DATA_W  host write data
host_rdata  out  DATA_W  combinational read of regfile[host_addr]
busy  out  1  high in every state except IDLE
rd_a_en  out  1  high in FETCH_A (reg1_out/alu_a equivalent)
rd_b_en  out  1  high in FETCH_B
alu_en  out  1  high in EXEC
wb_en  out  1  high in WRITE
pc_inc  out  1  high in WRITE
done  out  1  one-cycle pulse in DONE
result  out  DATA_W  last ALU result, registered
flag_z  out  1  result == 0, registered with result
flag_c  out  1  carry/borrow/shift-out, registered with result
illegal  out  1  last opcode was unsupported; held until next launch
pc  out  PC_W  program counter

Behaviour:
- Reset (reset==0 at posedge): state IDLE, all registers, operand latches, result, flags, illegal and pc are 0. All strobes are 0. Reset mid-operation aborts with no writeback and no pc increment.
- States are IDLE, FETCH_A, FETCH_B, EXEC, WRITE, DONE. Strobes are Moore-decoded from the registered state.
- IDLE -> FETCH_A when start==1. At the same edge, opcode/rs1/rs2/rd are latched and illegal is cleared. start seen in any other state is ignored, with no queuing.
- FETCH_A runs SETTLE cycles using a phase counter, then goes to FETCH_B. Operand A latches regfile[rs1] on the last FETCH_A cycle.
- FETCH_B runs SETTLE cycles; operand B latches on the last cycle. FETCH_B -> EXEC.
- EXEC (1 cycle) registers result, flag_z, flag_c and illegal. EXEC -> WRITE.
- WRITE (1 cycle) writes result to regfile[rd] unless rd==0 or illegal. pc increments modulo 2^PC_W (all-ones wraps to 0). WRITE -> DONE.
- DONE (1 cycle) -> IDLE. start sampled in the next IDLE cycle may relaunch.
- Latency: start accepted at edge 0 gives done high during cycle 2*SETTLE+3. With SETTLE=2 that is cycle 7; back-to-back throughput is one op per 2*SETTLE+4 cycles.
- Register 0 always reads 0. Writes to register 0 from host or writeback are discarded.
- Host write in IDLE takes effect at that edge. If start is asserted in the same cycle, the launched op sees the new value. host_we while busy is dropped.
- Opcodes, all mod 2^DATA_W:
  - 0 ADD (c = carry-out)
  - 1 SUB (c = borrow)
  - 2 AND, 3 OR, 4 XOR (c=0)
  - 5 SHL by B[2:0] (c = last bit shifted out)
  - 6 SHR logical (c = last bit shifted out)
  - 7 PASS A (c=0)
  - Shift by 0: c=0.
  - Others are illegal: result=0, z=1, c=0, illegal=1, no regfile write, pc still increments.

Optional Feature:
ALU_MUL_EN
- Defined: opcode 8 = MUL, giving the low DATA_W bits of A*B. c=1 if any high product bit is nonzero. EXEC remains one cycle.
- Undefined: opcode 8 is illegal, like opcodes 9-15.

Decomposition:
- Package alu_reg_pkg holds opcode localparams (OP_ADD..OP_MUL), the state enumeration, and an opcode-legal function.
- Sub-module alu_reg_alu: combinational ALU (a, b, opcode -> y, c, legal), parametrised by DATA_W. The FSM, regfile and pc stay in the top module.

Test Plan:
- Reset, host-write r1=0x05, r2=0x03, launch ADD rd=3 with SETTLE=2 -> done pulses exactly 7 cycles after start; r3=0x08, flag_z=0, flag_c=0, pc=1.
- SUB r2-r1 (0x03-0x05) into r4 -> r4=0xFE, flag_c=1; then SUB r1-r1 -> result 0, flag_z=1.
- Launch with rd=0, then with opcode 12 -> r0 stays 0, illegal=1 for the second op, no regfile change, pc still increments; next legal launch clears illegal.
- Pulse start during FETCH_B and host_we during EXEC -> both ignored, single done, regfile unchanged by the host.
- Preload pc=0xFF via 255 ops or force, run one op -> pc wraps to 0x00. Assert reset during EXEC -> next cycle IDLE, all outputs 0, no writeback.
- ALU_MUL_EN build: 0x10*0x11 -> result 0x10, flag_c=1. Non-MUL build: opcode 8 -> illegal=1.
